// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the MEM-stage data memory responder.
//   DATA_W    - data/address bus width
//   state_t   - responder FSM states
//   op_t      - operation latched at accept time
//   decode_op - maps the two request strobes onto op_t
package dmem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_ILLEGAL = 2'd2
    } op_t;

    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_ILLEGAL;
        end else if (wr) begin
            return OP_WRITE;
        end else begin
            return OP_READ;
        end
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU <-> data memory load/store handshake.
//   MemRead_i / MemWrite_i - request strobes, held by the CPU until ack_o
//   addr_i / data_i        - byte address and store data, held until ack_o
//   data_o                 - load data, valid at ack_o and held until next read ack
//   ack_o / err_o          - completion pulse and its rejection qualifier
//   stall_o                - freeze request to the hazard unit
// Modports: master = CPU side, slave = memory responder side.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemRead_i;
    logic              MemWrite_i;
    logic [DATA_W-1:0] addr_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              ack_o;
    logic              err_o;
    logic              stall_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, ack_o, err_o, stall_o
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH_WORDS x DATA_W word storage.
//   clk_i   - clock
//   we_i    - write enable, write takes effect on the rising edge
//   idx_i   - word index shared by read and write
//   wdata_i - write data
//   rdata_o - combinational read data at idx_i
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency responder for MEM-stage loads and stores.
//   clk_i - clock, rising edge
//   rst_i - synchronous active-low reset
//   bus   - dmem_responder_if.slave (requests in; data/ack/err/stall out)
// An access is accepted in IDLE, acked LATENCY cycles later in DONE.
// Misaligned or read+write requests complete with err_o and data_o=0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    op_t               op_q;
    logic [AW-1:0]     idx_q;
    logic              mis_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    op_t               op_e;
    logic [AW-1:0]     idx_e;
    logic              mis_e;
    logic [DATA_W-1:0] wdata_e;
    logic              req;
    logic              accept;
    logic              enter_done;
    logic              bad_e;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;
    logic              unused_addr_bits;

    assign req              = bus.MemRead_i | bus.MemWrite_i;
    assign unused_addr_bits = ^bus.addr_i[DATA_W-1:AW+2];

    // With LATENCY==1 the edge that accepts is also the edge entering DONE,
    // so the access is taken from the live inputs in IDLE and from the
    // latched copy otherwise; both carry the same values at that edge.
    always_comb begin
        if (state_q == IDLE) begin
            op_e    = decode_op(bus.MemRead_i, bus.MemWrite_i);
            idx_e   = bus.addr_i[AW+1:2];
            mis_e   = |bus.addr_i[1:0];
            wdata_e = bus.data_i;
        end else begin
            op_e    = op_q;
            idx_e   = idx_q;
            mis_e   = mis_q;
            wdata_e = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign bad_e      = (op_e == OP_ILLEGAL) || mis_e;
    // Gated by rst_i so a reset on the commit edge abandons the store.
    assign mem_we     = enter_done && rst_i && (op_e == OP_WRITE) && !mis_e;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (idx_e),
        .wdata_i (wdata_e),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= op_e;
                idx_q   <= idx_e;
                mis_q   <= mis_e;
                wdata_q <= wdata_e;
            end
            if (enter_done) begin
                err_q <= bad_e;
                if (bad_e) begin
                    data_q <= '0;
                end else if (op_e == OP_READ) begin
                    data_q <= rdata;
                end
            end
        end
    end

    assign bus.ack_o   = (state_q == DONE);
    assign bus.err_o   = (state_q == DONE) && err_q;
    assign bus.data_o  = data_q;
    assign bus.stall_o = req && (state_q != DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven bench for dmem_responder.
// Three instances with LATENCY 2, 1 and 4 share one clock.
module tb_dmem_responder;

    logic clk;
    logic rst2, rst1, rst4;

    dmem_responder_if if2 ();
    dmem_responder_if if1 ();
    dmem_responder_if if4 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .clk_i (clk), .rst_i (rst2), .bus (if2)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk_i (clk), .rst_i (rst1), .bus (if1)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk_i (clk), .rst_i (rst4), .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          id;      // 0: LATENCY 2, 1: LATENCY 1, 2: LATENCY 4
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int id);
        return (id == 0) ? 2 : (id == 1) ? 1 : 4;
    endfunction

    task automatic drive(input int id, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        case (id)
            0: begin if2.MemRead_i = rd; if2.MemWrite_i = wr; if2.addr_i = a; if2.data_i = d; end
            1: begin if1.MemRead_i = rd; if1.MemWrite_i = wr; if1.addr_i = a; if1.data_i = d; end
            default: begin if4.MemRead_i = rd; if4.MemWrite_i = wr; if4.addr_i = a; if4.data_i = d; end
        endcase
    endtask

    // {ack, err, stall, data}
    function automatic logic [34:0] outs(input int id);
        case (id)
            0:       return {if2.ack_o, if2.err_o, if2.stall_o, if2.data_o};
            1:       return {if1.ack_o, if1.err_o, if1.stall_o, if1.data_o};
            default: return {if4.ack_o, if4.err_o, if4.stall_o, if4.data_o};
        endcase
    endfunction

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic txn(input string tag, input int id, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_data);
        int L;
        logic [34:0] o;
        L = lat_of(id);
        drive(id, rd, wr, a, d);
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            o = outs(id);
            check($sformatf("%s ack c%0d", tag, c), {31'd0, o[34]}, {31'd0, (c == L)});
            check($sformatf("%s stall c%0d", tag, c), {31'd0, o[32]}, {31'd0, (c != L)});
            check($sformatf("%s err c%0d", tag, c), {31'd0, o[33]},
                  {31'd0, (c == L) ? exp_err : 1'b0});
            if (c == L) begin
                check($sformatf("%s data", tag), o[31:0], exp_data);
            end
            @(posedge clk);
            #1;
        end
        drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [34:0] o;

        //         id rd wr addr          wdata         err   exp_data
        tbl[0]  = '{0, 0, 1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{0, 1, 0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{0, 0, 1, 32'h0000_0000, 32'h12345678, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{0, 1, 0, 32'h0000_1000, 32'h0,        1'b0, 32'h12345678};
        tbl[4]  = '{0, 1, 0, 32'h0000_0006, 32'h0,        1'b1, 32'h0000_0000};
        tbl[5]  = '{0, 0, 1, 32'h0000_0002, 32'hFFFFFFFF, 1'b1, 32'h0000_0000};
        tbl[6]  = '{0, 1, 0, 32'h0000_0000, 32'h0,        1'b0, 32'h12345678};
        tbl[7]  = '{0, 0, 1, 32'h0000_0008, 32'h11112222, 1'b0, 32'h12345678};
        tbl[8]  = '{0, 1, 1, 32'h0000_0008, 32'h33334444, 1'b1, 32'h0000_0000};
        tbl[9]  = '{0, 1, 0, 32'h0000_0008, 32'h0,        1'b0, 32'h11112222};
        tbl[10] = '{0, 0, 1, 32'h0000_0FFC, 32'hCAFEF00D, 1'b0, 32'h11112222};
        tbl[11] = '{0, 1, 0, 32'h0000_7FFC, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[12] = '{1, 0, 1, 32'h0000_0000, 32'hA5A5A5A5, 1'b0, 32'h0000_0000};
        tbl[13] = '{1, 0, 1, 32'h0000_0004, 32'h5A5A5A5A, 1'b0, 32'h0000_0000};
        tbl[14] = '{1, 1, 0, 32'h0000_0000, 32'h0,        1'b0, 32'hA5A5A5A5};
        tbl[15] = '{1, 1, 0, 32'h0000_0004, 32'h0,        1'b0, 32'h5A5A5A5A};
        tbl[16] = '{1, 1, 0, 32'h0000_0002, 32'h0,        1'b1, 32'h0000_0000};
        tbl[17] = '{2, 0, 1, 32'h0000_0020, 32'h0BADF00D, 1'b0, 32'h0000_0000};
        tbl[18] = '{2, 1, 0, 32'h0000_0020, 32'h0,        1'b0, 32'h0BADF00D};

        rst2 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = outs(i);
            check($sformatf("reset ack u%0d", i),   {31'd0, o[34]}, 32'd0);
            check($sformatf("reset err u%0d", i),   {31'd0, o[33]}, 32'd0);
            check($sformatf("reset stall u%0d", i), {31'd0, o[32]}, 32'd0);
            check($sformatf("reset data u%0d", i),  o[31:0], 32'd0);
        end
        @(posedge clk);
        #1;

        // Entries run back to back: the next access starts in the cycle after an ack.
        for (int i = 0; i < 19; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].id, tbl[i].rd, tbl[i].wr,
                tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_data);
        end

        // Reset in the middle of a LATENCY=4 write to 0x20.
        drive(2, 1'b0, 1'b1, 32'h0000_0020, 32'hAAAA5555);       // cycle 0
        @(posedge clk); #1;                                       // cycle 1
        @(posedge clk); #1;                                       // cycle 2
        rst4 = 1'b0;
        @(negedge clk);
        o = outs(2);
        check("rst-mid stall c2", {31'd0, o[32]}, 32'd1);
        check("rst-mid ack c2",   {31'd0, o[34]}, 32'd0);
        @(posedge clk); #1;                                       // cycle 3
        @(negedge clk);
        o = outs(2);
        check("rst-mid ack c3",   {31'd0, o[34]}, 32'd0);
        check("rst-mid err c3",   {31'd0, o[33]}, 32'd0);
        check("rst-mid stall c3", {31'd0, o[32]}, 32'd1);
        check("rst-mid data c3",  o[31:0], 32'd0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        o = outs(2);
        check("rst-mid stall noreq", {31'd0, o[32]}, 32'd0);
        @(posedge clk); #1;
        rst4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            o = outs(2);
            check($sformatf("rst-mid idle ack %0d", c), {31'd0, o[34]}, 32'd0);
            @(posedge clk); #1;
        end
        txn("rst-mid readback", 2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the pipeline's MEM-stage load/store interface: accepts a word read or write from the CPU, serves it from an internal word-addressed array after a fixed programmable latency, and signals completion.
- Drives stall_o back to the hazard logic so the pipeline freezes until the access completes.
- Sits between the EX/MEM pipeline register outputs and the MEM/WB register inputs. Replaces the zero-latency data memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from accept to ack; legal range 1..15.
- AW, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- MemRead_i  input  1  load request; held by CPU until ack_o.
- MemWrite_i  input  1  store request; held by CPU until ack_o.
- addr_i  input  32  byte address; held stable until ack_o.
- data_i  input  32  store data; held stable until ack_o.
- data_o  output  32  load data; valid in the ack_o cycle and held until the next read ack.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  qualifies ack_o: the access was rejected.
- stall_o  output  1  combinational freeze request to the hazard unit.

Behaviour:
- Reset (rst_i==0 at an edge): state=IDLE, ack_o=0, err_o=0, data_o=0, counter=0. Array contents are not cleared. Reset mid-transaction abandons the access and no write occurs.
- req = MemRead_i | MemWrite_i.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if req, latch addr_i, data_i and the operation, then go to WAIT with counter=LATENCY-2. If LATENCY==1, go directly to DONE.
  - WAIT: decrement the counter. When the counter==0, go to DONE at the next edge.
  - DONE: ack_o=1 for exactly this cycle, then IDLE unconditionally.
- Latency: request accepted in cycle 0 (IDLE sees req). ack_o is high in cycle LATENCY. The next request can be accepted in cycle LATENCY+1.
- Write commit and read capture both happen on the edge entering DONE, from the latched values. A write is visible to a read accepted afterwards.
- Word index = latched addr[AW+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
- Error cases, each with ack_o=1 and err_o=1 at normal latency:
  - Misaligned: addr[1:0]!=0. No write; data_o forced to 0.
  - Both MemRead_i and MemWrite_i high at accept: no access; data_o forced to 0.
- err_o=0 whenever ack_o=0.
- stall_o = req & (state!=DONE).
  - stall_o is 0 in the ack cycle, so the pipeline advances on that edge.
  - stall_o is 0 when there is no request.
- Inputs that change while in WAIT are ignored; the latched values govern. Inputs are sampled again only in IDLE.
- data_o is unchanged on write acks and in all non-ack cycles.

Decomposition:
- Package dmem_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, DONE=2'd2
  - DATA_W=32
  - OP_READ / OP_WRITE / OP_ILLEGAL encoding for the latched operation
- One sub-module, dmem_array: DEPTH_WORDS x 32. Synchronous write with a write-enable; combinational read by index. The FSM registers the read data into data_o.

Test Plan:
- Reset, then write 32'hDEADBEEF to addr 0x10 with LATENCY=2 → stall_o high in cycles 0-1, ack_o=1 and stall_o=0 in cycle 2, err_o=0; a following read of 0x10 returns data_o=32'hDEADBEEF at its ack.
- LATENCY=1: read accepted in cycle 0 → ack in cycle 1; back-to-back reads of 0x0 and 0x4 are acked in cycles 1 and 3.
- Write 32'h12345678 to 0x0, then read addr 4*DEPTH_WORDS (0x1000) → data_o=32'h12345678 (wrap-around).
- Read 0x6 (misaligned) → ack_o=1, err_o=1, data_o=0. Write 0x2 with data 32'hFFFFFFFF → err, and a later read of 0x0 still returns its old value.
- MemRead_i=MemWrite_i=1 to 0x8 → ack+err at LATENCY, array unchanged.
- Start a write of 32'hAAAA5555 to 0x20 (LATENCY=4) and pull rst_i low in cycle 2 → next cycle ack_o=0 and stall_o follows req only; after reset, a read of 0x20 returns its pre-write value.
